// File: rtl/spi_slave.sv
// SPI peripheral end: 8-bit MSB-first full-duplex frames, run-time CPOL/CPHA, pins synchronised into clk.
// Optional sticky RX overrun detection is enabled by defining SPI_SLAVE_OVERRUN_EN.
module spi_slave #(
    parameter logic [7:0] IDLE_BYTE = 8'hFF
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cpol,
    input  logic       cpha,
    input  logic [7:0] tx_data,
    input  logic       tx_wr,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_done_tick,
    input  logic       rx_rd,
    output logic       rx_overrun,
    output logic       busy,
    input  logic       sclk,
    input  logic       ss_n,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe
);

    typedef enum logic {ST_IDLE = 1'b0, ST_XFER = 1'b1} state_t;

    state_t     state_q;
    logic [2:0] sclk_q;
    logic [2:0] ss_q;
    logic [1:0] mosi_q;
    logic [7:0] shifter_q;
    logic [7:0] si_q;
    logic [2:0] n_q;
    logic [7:0] tx_buf_q;
    logic       tx_ready_q;
    logic [7:0] rx_data_q;
    logic       rx_done_tick_q;
    logic       busy_q;
    logic       miso_oe_q;

    logic       sclk_chg_s;
    logic       lead_s;
    logic       trail_s;
    logic       sample_s;
    logic       shift_s;
    logic       ss_fall_s;
    logic       ss_rise_s;
    logic       load_s;
    logic [7:0] load_byte_s;

    // Bit [1] is the synchronised level; bit [2] is its delayed copy for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_q <= 3'b000;
            ss_q   <= 3'b111;
            mosi_q <= 2'b00;
        end else begin
            sclk_q <= {sclk_q[1:0], sclk};
            ss_q   <= {ss_q[1:0], ss_n};
            mosi_q <= {mosi_q[0], mosi};
        end
    end

    assign sclk_chg_s  = sclk_q[1] ^ sclk_q[2];
    assign lead_s      = sclk_chg_s & (sclk_q[1] != cpol);
    assign trail_s     = sclk_chg_s & (sclk_q[1] == cpol);
    assign sample_s    = cpha ? trail_s : lead_s;
    assign shift_s     = cpha ? lead_s : trail_s;
    assign ss_fall_s   = ~ss_q[1] & ss_q[2];
    assign ss_rise_s   = ss_q[1] & ~ss_q[2];
    assign load_byte_s = tx_ready_q ? IDLE_BYTE : tx_buf_q;
    assign load_s      = ((state_q == ST_IDLE) && ss_fall_s && !cpha) ||
                         ((state_q == ST_XFER) && !ss_rise_s && shift_s && (n_q == 3'd0));

    // Transfer FSM with shifter, receive path and TX holding register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            shifter_q      <= 8'h00;
            si_q           <= 8'h00;
            n_q            <= 3'd0;
            tx_buf_q       <= 8'h00;
            tx_ready_q     <= 1'b1;
            rx_data_q      <= 8'h00;
            rx_done_tick_q <= 1'b0;
            busy_q         <= 1'b0;
            miso_oe_q      <= 1'b0;
        end else begin
            rx_done_tick_q <= 1'b0;
            if (load_s) begin
                shifter_q  <= load_byte_s;
                tx_ready_q <= 1'b1;
            end
            // A write in the same cycle as a load keeps the new byte pending.
            if (tx_wr) begin
                tx_buf_q   <= tx_data;
                tx_ready_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (ss_fall_s) begin
                        state_q   <= ST_XFER;
                        busy_q    <= 1'b1;
                        miso_oe_q <= 1'b1;
                        n_q       <= 3'd0;
                    end
                end
                ST_XFER: begin
                    if (ss_rise_s) begin
                        state_q   <= ST_IDLE;
                        busy_q    <= 1'b0;
                        miso_oe_q <= 1'b0;
                        n_q       <= 3'd0;
                    end else begin
                        if (shift_s && (n_q != 3'd0)) begin
                            shifter_q <= {shifter_q[6:0], 1'b0};
                        end
                        if (sample_s) begin
                            si_q <= {si_q[6:0], mosi_q[1]};
                            n_q  <= n_q + 3'd1;
                            if (n_q == 3'd7) begin
                                rx_data_q      <= {si_q[6:0], mosi_q[1]};
                                rx_done_tick_q <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef SPI_SLAVE_OVERRUN_EN
    logic rx_valid_q;
    logic rx_overrun_q;

    // Unread-byte tracking; a new byte arriving over an unread one is sticky until rx_rd.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_valid_q   <= 1'b0;
            rx_overrun_q <= 1'b0;
        end else begin
            if (rx_done_tick_q) begin
                rx_valid_q <= 1'b1;
            end else if (rx_rd) begin
                rx_valid_q <= 1'b0;
            end
            if (rx_rd) begin
                rx_overrun_q <= 1'b0;
            end else if (rx_done_tick_q && rx_valid_q) begin
                rx_overrun_q <= 1'b1;
            end
        end
    end

    assign rx_overrun = rx_overrun_q;
`else
    logic unused_rx_rd_s;
    assign unused_rx_rd_s = rx_rd;
    assign rx_overrun     = 1'b0;
`endif

    assign tx_ready     = tx_ready_q;
    assign rx_data      = rx_data_q;
    assign rx_done_tick = rx_done_tick_q;
    assign busy         = busy_q;
    assign miso         = shifter_q[7];
    assign miso_oe      = miso_oe_q;

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: bench-side SPI master, RX scoreboard checked on every rx_done_tick.
// Define SPI_SLAVE_OVERRUN_EN for both RTL and bench to exercise the overrun flag.
module tb_spi_slave;

    localparam int H = 6;
    localparam int S = 8;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       cpol = 1'b0;
    logic       cpha = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_wr = 1'b0;
    logic       rx_rd = 1'b0;
    logic       sclk = 1'b0;
    logic       ss_n = 1'b1;
    logic       mosi = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_done_tick;
    logic       rx_overrun;
    logic       busy;
    logic       miso;
    logic       miso_oe;

    int         n_chk = 0;
    int         n_pass = 0;
    int         cyc = 0;
    int         n_ticks = 0;
    int         tick_cyc[$];
    logic [7:0] sb[$];

    spi_slave #(.IDLE_BYTE(8'hFF)) dut (
        .clk(clk), .reset_n(reset_n), .cpol(cpol), .cpha(cpha),
        .tx_data(tx_data), .tx_wr(tx_wr), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_done_tick(rx_done_tick), .rx_rd(rx_rd),
        .rx_overrun(rx_overrun), .busy(busy), .sclk(sclk), .ss_n(ss_n),
        .mosi(mosi), .miso(miso), .miso_oe(miso_oe)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Scoreboard: every received byte must match the oldest byte the master sent.
    always @(negedge clk) begin
        if (rx_done_tick === 1'b1) begin
            n_ticks++;
            tick_cyc.push_back(cyc);
            chk("rx_pending", (sb.size() > 0), 1'b1);
            if (sb.size() > 0) chk("rx_data", rx_data, sb.pop_front());
        end
    end

    task automatic clk_wait(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_mode(input logic p, input logic h);
        cpol = p;
        cpha = h;
        sclk = p;
        clk_wait(4);
    endtask

    task automatic write_tx(input logic [7:0] d);
        tx_data = d;
        tx_wr   = 1'b1;
        clk_wait(1);
        tx_wr   = 1'b0;
    endtask

    task automatic pulse_rd();
        rx_rd = 1'b1;
        clk_wait(1);
        rx_rd = 1'b0;
    endtask

    task automatic ss_begin();
        ss_n = 1'b0;
        clk_wait(S);
    endtask

    task automatic ss_end();
        clk_wait(H);
        ss_n = 1'b1;
        clk_wait(6);
    endtask

    task automatic xfer_bits(input logic [7:0] b, input int nb, output logic [7:0] r);
        r = 8'h00;
        for (int i = 0; i < nb; i++) begin
            if (!cpha) begin
                mosi = b[7-i];
                clk_wait(H);
                sclk = ~cpol;
                r[7-i] = miso;
                clk_wait(H);
                sclk = cpol;
            end else begin
                clk_wait(H);
                sclk = ~cpol;
                mosi = b[7-i];
                clk_wait(H);
                sclk = cpol;
                r[7-i] = miso;
            end
        end
    endtask

    initial begin
        logic [7:0] r1;
        logic [7:0] r2;
        logic [7:0] mb;
        logic       exp_ovr;
        int         t0;
        int         dt;

        clk_wait(3);
        chk("reset_outs", {tx_ready, rx_data, rx_done_tick, rx_overrun, busy, miso, miso_oe},
            {1'b1, 8'h00, 5'b00000});
        reset_n = 1'b1;
        clk_wait(3);

        // Mode 0 single byte
        set_mode(1'b0, 1'b0);
        write_tx(8'hA5);
        chk("m0_txrdy_full", tx_ready, 1'b0);
        t0 = n_ticks;
        sb.push_back(8'h3C);
        ss_begin();
        chk("m0_busy_oe", {busy, miso_oe}, 2'b11);
        chk("m0_txrdy_load", tx_ready, 1'b1);
        xfer_bits(8'h3C, 8, r1);
        ss_end();
        chk("m0_miso", r1, 8'hA5);
        chk("m0_rx_data", rx_data, 8'h3C);
        chk("m0_ticks", n_ticks - t0, 1);
        chk("m0_idle", {busy, miso_oe}, 2'b00);

        // Modes 1..3
        for (int m = 1; m < 4; m++) begin
            set_mode(m[1], m[0]);
            mb = (m == 2) ? 8'h7E : 8'h81;
            write_tx(8'hC3);
            sb.push_back(mb);
            ss_begin();
            xfer_bits(mb, 8, r1);
            ss_end();
            chk($sformatf("m%0d_miso", m), r1, 8'hC3);
            chk($sformatf("m%0d_rx_data", m), rx_data, mb);
        end

        // Back-to-back bytes with ss_n held low, TX empty for the second
        set_mode(1'b0, 1'b0);
        pulse_rd();
        write_tx(8'h5A);
        t0 = n_ticks;
        tick_cyc.delete();
        sb.push_back(8'h11);
        sb.push_back(8'h22);
        ss_begin();
        xfer_bits(8'h11, 8, r1);
        xfer_bits(8'h22, 8, r2);
        ss_end();
        chk("b2b_miso1", r1, 8'h5A);
        chk("b2b_miso2", r2, 8'hFF);
        chk("b2b_ticks", n_ticks - t0, 2);
        dt = (tick_cyc.size() >= 2) ? (tick_cyc[1] - tick_cyc[0]) : 0;
        chk("b2b_tick_gap", dt, 16 * H);
`ifdef SPI_SLAVE_OVERRUN_EN
        exp_ovr = 1'b1;
`else
        exp_ovr = 1'b0;
`endif
        chk("ovr_set", rx_overrun, exp_ovr);
        pulse_rd();
        chk("ovr_clear", rx_overrun, 1'b0);

        // Abort after 5 bits, then TX overwrite and a clean transfer
        write_tx(8'h77);
        t0 = n_ticks;
        ss_begin();
        xfer_bits(8'hF0, 5, r1);
        ss_n = 1'b1;
        clk_wait(3);
        chk("abort_busy", {busy, miso_oe}, 2'b00);
        clk_wait(10);
        chk("abort_no_tick", n_ticks - t0, 0);
        write_tx(8'h11);
        write_tx(8'h66);
        sb.push_back(8'h96);
        ss_begin();
        xfer_bits(8'h96, 8, r1);
        ss_end();
        chk("after_abort_miso", r1, 8'h66);
        chk("after_abort_ticks", n_ticks - t0, 1);

        // Asynchronous reset mid-byte
        set_mode(1'b1, 1'b1);
        write_tx(8'h44);
        ss_begin();
        xfer_bits(8'hAA, 3, r1);
        write_tx(8'h55);
        t0 = n_ticks;
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_async", {tx_ready, rx_data, rx_done_tick, rx_overrun, busy, miso, miso_oe},
            {1'b1, 8'h00, 5'b00000});
        ss_n = 1'b1;
        sclk = cpol;
        clk_wait(5);
        reset_n = 1'b1;
        clk_wait(20);
        chk("rst_no_tick", n_ticks - t0, 0);
        write_tx(8'h3C);
        sb.push_back(8'hE7);
        ss_begin();
        xfer_bits(8'hE7, 8, r1);
        ss_end();
        chk("post_rst_miso", r1, 8'h3C);
        chk("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
